// File: rtl/memory_arbiter.sv
// Two-master (instruction fetch / data) arbiter and sequencer in front of the
// memory controller processor interface, with a per-transaction watchdog.
module memory_arbiter #(
  parameter int unsigned BYTE_AMNT      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     inst_req,
  input  logic [8*BYTE_AMNT-1:0]   inst_addr,
  output logic [8*BYTE_AMNT-1:0]   inst_rd_data,
  output logic                     inst_ack,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [BYTE_AMNT-1:0]     data_byte_en,
  input  logic [8*BYTE_AMNT-1:0]   data_addr,
  input  logic [8*BYTE_AMNT-1:0]   data_wr_data,
  output logic [8*BYTE_AMNT-1:0]   data_rd_data,
  output logic                     data_ack,
  output logic                     bus_error,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [BYTE_AMNT-1:0]     mem_byte_en,
  output logic [8*BYTE_AMNT-1:0]   mem_addr,
  output logic [8*BYTE_AMNT-1:0]   wr_data,
  input  logic [8*BYTE_AMNT-1:0]   rd_data,
  input  logic                     mem_busy
);

  localparam int unsigned DW = 8 * BYTE_AMNT;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic G_INST = 1'b0;
  localparam logic G_DATA = 1'b1;

  logic [1:0]           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic                 wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [BYTE_AMNT-1:0] be_q, be_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [DW-1:0]        inst_rd_q, inst_rd_d;
  logic [DW-1:0]        data_rd_q, data_rd_d;
  logic                 inst_ack_q, inst_ack_d;
  logic                 data_ack_q, data_ack_d;
  logic                 bus_err_q, bus_err_d;

  logic                 gnt_c;
  logic                 wr_sel_c;
  logic [CW-1:0]        cnt_inc_c;

  // State register and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_INST;
      grant_q      <= G_INST;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      inst_rd_q    <= '0;
      data_rd_q    <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      inst_rd_q    <= inst_rd_d;
      data_rd_q    <= data_rd_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next-state logic; enables and acks are computed one cycle ahead so that
  // the registered outputs line up with the ISSUE/WAIT and DONE states.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    inst_rd_d    = inst_rd_q;
    data_rd_d    = data_rd_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    bus_err_d    = 1'b0;
    gnt_c        = G_INST;
    wr_sel_c     = 1'b0;
    cnt_inc_c    = CW'(cnt_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          // Round-robin on contention, otherwise the lone requester wins
          if (inst_req && data_req) gnt_c = ~last_grant_q;
          else                      gnt_c = data_req ? G_DATA : G_INST;
          grant_d      = gnt_c;
          last_grant_d = gnt_c;
          if (gnt_c == G_DATA) begin
            wr_sel_c = data_wr;
            addr_d   = data_addr;
            be_d     = data_byte_en;
            wdata_d  = data_wr_data;
          end else begin
            wr_sel_c = 1'b0;
            addr_d   = inst_addr;
            be_d     = '1;
          end
          wr_d    = wr_sel_c;
          rd_en_d = ~wr_sel_c;
          wr_en_d = wr_sel_c;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Devices raise busy one cycle late, so busy is not looked at here
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc_c;
        if (!mem_busy) begin
          if (!wr_q) begin
            if (grant_q == G_DATA) data_rd_d = rd_data;
            else                   inst_rd_d = rd_data;
          end
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          inst_ack_d = (grant_q == G_INST);
          data_ack_d = (grant_q == G_DATA);
          state_d    = S_DONE;
        end else if (cnt_inc_c == CW'(TIMEOUT_CYCLES)) begin
          // Watchdog: terminate after TIMEOUT_CYCLES cycles spent in WAIT
          if (!wr_q) begin
            if (grant_q == G_DATA) data_rd_d = '0;
            else                   inst_rd_d = '0;
          end
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          bus_err_d  = 1'b1;
          inst_ack_d = (grant_q == G_INST);
          data_ack_d = (grant_q == G_DATA);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inst_rd_data = inst_rd_q;
  assign inst_ack     = inst_ack_q;
  assign data_rd_data = data_rd_q;
  assign data_ack     = data_ack_q;
  assign bus_error    = bus_err_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_byte_en  = be_q;
  assign mem_addr     = addr_q;
  assign wr_data      = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, write, zero-wait reads, watchdog,
// mid-transaction reset and round-robin contention.
module tb_memory_arbiter;

  localparam int unsigned BA = 8;
  localparam int unsigned DW = 8 * BA;

  logic          clock;
  logic          reset_n;
  logic          inst_req;
  logic [DW-1:0] inst_addr;
  logic [DW-1:0] inst_rd_data;
  logic          inst_ack;
  logic          data_req;
  logic          data_wr;
  logic [BA-1:0] data_byte_en;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] data_wr_data;
  logic [DW-1:0] data_rd_data;
  logic          data_ack;
  logic          bus_error;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [BA-1:0] mem_byte_en;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          mem_busy;

  int n_vec;
  int n_err;

  memory_arbiter #(.BYTE_AMNT(BA), .TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rd_data (inst_rd_data),
    .inst_ack     (inst_ack),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_byte_en (data_byte_en),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .bus_error    (bus_error),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_byte_en  (mem_byte_en),
    .mem_addr     (mem_addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .mem_busy     (mem_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n      = 1'b0;
    inst_req     = 1'b0;
    inst_addr    = '0;
    data_req     = 1'b0;
    data_wr      = 1'b0;
    data_byte_en = '0;
    data_addr    = '0;
    data_wr_data = '0;
    rd_data      = '0;
    mem_busy     = 1'b0;

    // Reset state
    step(); step();
    chk("rst_inst_ack", 64'(inst_ack), 64'h0);
    chk("rst_data_ack", 64'(data_ack), 64'h0);
    chk("rst_bus_error", 64'(bus_error), 64'h0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_byte_en", 64'(mem_byte_en), 64'h0);
    reset_n = 1'b1;

    // Single fetch, device busy for 3 WAIT cycles
    inst_addr = 64'h0000_0000_0000_0100;
    inst_req  = 1'b1;
    step();
    chk("fetch_issue_rd_en", 64'(mem_rd_en), 64'h1);
    chk("fetch_issue_wr_en", 64'(mem_wr_en), 64'h0);
    chk("fetch_issue_be", 64'(mem_byte_en), 64'hFF);
    chk("fetch_issue_addr", mem_addr, 64'h100);
    mem_busy = 1'b1;
    step(); step(); step();
    chk("fetch_wait_rd_en", 64'(mem_rd_en), 64'h1);
    chk("fetch_wait_ack", 64'(inst_ack), 64'h0);
    mem_busy = 1'b0;
    rd_data  = 64'h1122334455667788;
    step();
    chk("fetch_done_ack", 64'(inst_ack), 64'h1);
    chk("fetch_done_data_ack", 64'(data_ack), 64'h0);
    chk("fetch_rd_data", inst_rd_data, 64'h1122334455667788);
    chk("fetch_done_rd_en", 64'(mem_rd_en), 64'h0);
    inst_req = 1'b0;
    step();
    chk("fetch_ack_single", 64'(inst_ack), 64'h0);

    // Data write with partial byte enables
    data_wr      = 1'b1;
    data_addr    = 64'h0000_0000_0100_0008;
    data_byte_en = 8'h0F;
    data_wr_data = 64'hDEADBEEF;
    data_req     = 1'b1;
    step();
    chk("wr_issue_wr_en", 64'(mem_wr_en), 64'h1);
    chk("wr_issue_rd_en", 64'(mem_rd_en), 64'h0);
    chk("wr_issue_data", wr_data, 64'hDEADBEEF);
    chk("wr_issue_be", 64'(mem_byte_en), 64'h0F);
    chk("wr_issue_addr", mem_addr, 64'h0000_0000_0100_0008);
    mem_busy = 1'b1;
    step();
    data_wr_data = 64'h0BAD_0BAD;
    step();
    chk("wr_wait_wr_en", 64'(mem_wr_en), 64'h1);
    chk("wr_wait_data_stable", wr_data, 64'hDEADBEEF);
    chk("wr_wait_be_stable", 64'(mem_byte_en), 64'h0F);
    mem_busy = 1'b0;
    step();
    chk("wr_done_ack", 64'(data_ack), 64'h1);
    chk("wr_done_inst_ack", 64'(inst_ack), 64'h0);
    chk("wr_rd_data_unchanged", data_rd_data, 64'h0);
    chk("wr_done_wr_en", 64'(mem_wr_en), 64'h0);
    data_req = 1'b0;
    step();

    // Zero-wait back-to-back reads
    data_wr      = 1'b0;
    data_byte_en = 8'hFF;
    data_addr    = 64'h10;
    rd_data      = 64'hA1;
    data_req     = 1'b1;
    step();
    chk("zw1_issue_addr", mem_addr, 64'h10);
    chk("zw1_issue_rd_en", 64'(mem_rd_en), 64'h1);
    step(); step();
    chk("zw1_done_ack", 64'(data_ack), 64'h1);
    chk("zw1_rd_data", data_rd_data, 64'hA1);
    data_addr = 64'h18;
    rd_data   = 64'hB2;
    chk("zw1_done_addr_hold", mem_addr, 64'h10);
    step();
    chk("zw_idle_ack", 64'(data_ack), 64'h0);
    chk("zw_idle_addr_hold", mem_addr, 64'h10);
    step();
    chk("zw2_issue_addr", mem_addr, 64'h18);
    step(); step();
    chk("zw2_done_ack", 64'(data_ack), 64'h1);
    chk("zw2_rd_data", data_rd_data, 64'hB2);
    data_req = 1'b0;
    step();

    // Watchdog: busy stuck high for the whole transaction
    data_addr = 64'h20;
    rd_data   = 64'hFFFF_FFFF;
    mem_busy  = 1'b1;
    data_req  = 1'b1;
    step();
    repeat (8) step();
    chk("to_wait8_ack", 64'(data_ack), 64'h0);
    chk("to_wait8_rd_en", 64'(mem_rd_en), 64'h1);
    step();
    chk("to_done_ack", 64'(data_ack), 64'h1);
    chk("to_done_bus_error", 64'(bus_error), 64'h1);
    chk("to_rd_data_zero", data_rd_data, 64'h0);
    chk("to_done_rd_en", 64'(mem_rd_en), 64'h0);
    data_req = 1'b0;
    mem_busy = 1'b0;
    step();
    chk("to_bus_error_pulse", 64'(bus_error), 64'h0);
    data_addr = 64'h28;
    rd_data   = 64'hC3;
    data_req  = 1'b1;
    step(); step(); step();
    chk("post_to_ack", 64'(data_ack), 64'h1);
    chk("post_to_bus_error", 64'(bus_error), 64'h0);
    chk("post_to_rd_data", data_rd_data, 64'hC3);
    data_req = 1'b0;
    step();

    // Asynchronous reset in the middle of a WAIT
    inst_addr = 64'h300;
    inst_req  = 1'b1;
    step();
    mem_busy = 1'b1;
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rd_en", 64'(mem_rd_en), 64'h0);
    chk("arst_addr", mem_addr, 64'h0);
    chk("arst_be", 64'(mem_byte_en), 64'h0);
    chk("arst_inst_rd_data", inst_rd_data, 64'h0);
    chk("arst_data_rd_data", data_rd_data, 64'h0);
    chk("arst_inst_ack", 64'(inst_ack), 64'h0);

    // Contention from reset: DATA, INST, DATA, INST
    data_req  = 1'b1;
    data_addr = 64'h40;
    inst_addr = 64'h80;
    mem_busy  = 1'b0;
    step(); step();
    chk("arst_hold_ack", 64'(inst_ack), 64'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic is_data;
      is_data = (k % 2 == 0);
      rd_data = 64'h1000 + 64'(k);
      step();
      chk("rr_issue_addr", mem_addr, is_data ? 64'h40 : 64'h80);
      step(); step();
      chk("rr_done_inst_ack", 64'(inst_ack), is_data ? 64'h0 : 64'h1);
      chk("rr_done_data_ack", 64'(data_ack), is_data ? 64'h1 : 64'h0);
      chk("rr_rd_data", is_data ? data_rd_data : inst_rd_data, 64'h1000 + 64'(k));
      step();
      chk("rr_idle_acks", 64'({inst_ack, data_ack}), 64'h0);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-master arbiter and sequencer in front of memory_controller's processor interface.
- Shares the interface between the instruction-fetch port (read-only) and the data port (read/write, byte enables).
- Registers each transaction, holds the bus stable until the addressed device drops mem_busy, and returns read data with a one-cycle acknowledge.
- Includes a watchdog that terminates transactions whose device never responds.

Parameters:
- BYTE_AMNT, 8, bus width in bytes; data/address width = 8*BYTE_AMNT.
- TIMEOUT_CYCLES, 255, WAIT cycles before forced termination; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- inst_req  input  1  fetch request; held until inst_ack
- inst_addr  input  8*BYTE_AMNT  fetch address
- inst_rd_data  output  8*BYTE_AMNT  fetch data; valid with inst_ack
- inst_ack  output  1  one-cycle completion pulse
- data_req  input  1  data request; held until data_ack
- data_wr  input  1  1 = write, 0 = read
- data_byte_en  input  BYTE_AMNT  byte enables
- data_addr  input  8*BYTE_AMNT  data address
- data_wr_data  input  8*BYTE_AMNT  write data
- data_rd_data  output  8*BYTE_AMNT  read data; valid with data_ack
- data_ack  output  1  one-cycle completion pulse
- bus_error  output  1  pulses together with an ack when the transaction timed out
- mem_rd_en  output  1  to memory_controller
- mem_wr_en  output  1  to memory_controller
- mem_byte_en  output  BYTE_AMNT  to memory_controller
- mem_addr  output  8*BYTE_AMNT  to memory_controller
- wr_data  output  8*BYTE_AMNT  to memory_controller
- rd_data  input  8*BYTE_AMNT  from memory_controller
- mem_busy  input  1  from memory_controller (combinational from device)

Behaviour:
- Reset (asynchronous on reset_n low):
  - State IDLE, last_grant = INST.
  - All outputs 0, including mem_* outputs, data registers, acks and bus_error.
  - Timeout counter 0.
- Reset mid-transaction aborts immediately. No ack is issued, and nothing is replayed after release.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On any req, arbitrate and latch into registers: grant, address, byte_en, wr_data and direction. Go to ISSUE.
  - Inst fetches force mem_byte_en to all ones and rd direction.
  - Arbitration is round-robin on simultaneous requests: grant the master that did not win last_grant. A single requester wins unconditionally.
  - last_grant updates on every grant.
- ISSUE (1 cycle):
  - Drive mem_addr, wr_data, mem_byte_en from the registers.
  - Drive mem_rd_en = ~wr and mem_wr_en = wr.
  - mem_busy is ignored, because devices raise busy one cycle late. Always go to WAIT.
- WAIT:
  - Keep all mem_* outputs and enables stable. Increment the timeout counter.
  - If mem_busy == 0: capture rd_data into the granted master's rd_data register (reads only), deassert enables, go to DONE.
  - Else if counter == TIMEOUT_CYCLES: deassert enables, set the error flag, load 0 into the read data register, go to DONE.
- DONE (1 cycle):
  - Pulse the granted master's ack. Pulse bus_error if the error flag is set.
  - mem_* enables are 0. Clear counter and flag. Return to IDLE.
  - A req still high in the DONE cycle is ignored. New arbitration happens in IDLE on the following cycle.
  - Minimum transaction therefore takes 4 cycles (IDLE→ISSUE→WAIT→DONE) for a zero-wait device.
- rd_data registers hold their value until the next completed read for that master. Writes leave data_rd_data unchanged.
- Master inputs are sampled only in IDLE. Changes to an in-flight master's inputs are ignored until its ack.
- Outside ISSUE/WAIT: mem_rd_en = mem_wr_en = 0. mem_addr, wr_data and mem_byte_en hold their last values.
- Never more than one ack per cycle. inst_ack and data_ack are mutually exclusive.
- A request dropped before its ack is a protocol violation. The transaction completes anyway and the ack is still pulsed.

Test Plan:
1. Reset: reset_n=0 while in WAIT → all outputs 0 asynchronously. After release, no ack is issued, and a pending inst_req is arbitrated fresh from IDLE.
2. Single fetch: inst_req, inst_addr=0x0000_0000_0000_0100, ROM model busy for 3 cycles, rd_data=0x1122334455667788 → inst_ack pulses exactly once. inst_rd_data=0x1122334455667788, mem_rd_en high ISSUE→WAIT, mem_byte_en=0xFF, mem_wr_en never set.
3. Data write: data_wr=1, data_addr=0x0000_0000_0100_0008, data_byte_en=0x0F, data_wr_data=0xDEADBEEF → mem_wr_en=1, wr_data=0xDEADBEEF, mem_byte_en=0x0F stable until busy falls. data_ack pulses; data_rd_data unchanged.
4. Contention: inst_req and data_req held continuously from reset → grants alternate INST? No: last_grant=INST at reset, so the order is DATA, INST, DATA, INST. Acks are 1-cycle and never simultaneous; each master gets 2 of 4 transactions.
5. Timeout: TIMEOUT_CYCLES=8, mem_busy stuck at 1 → enables drop, and data_ack and bus_error pulse together after 8 WAIT cycles. data_rd_data=0; the next request proceeds normally.
6. Zero-wait device: mem_busy=0 always, back-to-back data reads 0x10, 0x18 → each completes in 4 cycles. rd_data is captured on the WAIT cycle and the second address appears only after the first ack.
